// File: rtl/aes256_inv_key_sched.sv
// AES-256 round-key source: expands the key forward once, then emits round keys 14..0
// by undoing the schedule in place. Optional key-window cache: AES_INVKEY_CACHE_EN.
module aes256_inv_key_sched_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x12;
    logic [7:0] x240;
    logic [7:0] inv;
    x2  = gf_mul(a, a);
    x3  = gf_mul(x2, a);
    x12 = gf_mul(x3, x3);
    x12 = gf_mul(x12, x12);
    x240 = gf_mul(x12, x3);
    for (int unsigned i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
endmodule

module aes256_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic         start,
`ifdef AES_INVKEY_CACHE_EN
  input  logic         reuse,
`endif
  output logic         busy,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_idx,
  output logic         rkey_valid,
  input  logic         rkey_ready
);
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t       state, state_next;
  logic [127:0] half_a, half_b;
  logic [3:0]   step;
  logic [3:0]   rc_step;
  logic [7:0]   rcon;
  logic [31:0]  sub_a, sub_b;
  logic [31:0]  t_even, t_odd;
  logic [127:0] fwd_a, fwd_b, undo_a, undo_b;
  logic         use_cache;

  function automatic logic [127:0] chain(input logic [127:0] h, input logic [31:0] t);
    logic [31:0] n0, n1, n2, n3;
    n0 = h[127:96] ^ t;
    n1 = n0 ^ h[95:64];
    n2 = n1 ^ h[63:32];
    n3 = n2 ^ h[31:0];
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] unchain(input logic [127:0] n, input logic [31:0] t);
    return {n[127:96] ^ t, n[95:64] ^ n[127:96], n[63:32] ^ n[95:64], n[31:0] ^ n[63:32]};
  endfunction

  // One S-box path per half: sub_a serves odd steps, sub_b serves even steps, both ways
  aes256_inv_key_sched_subword u_sub_a (.din(half_a[31:0]), .dout(sub_a));
  aes256_inv_key_sched_subword u_sub_b (.din({half_b[23:0], half_b[31:24]}), .dout(sub_b));

  // Undoing at index i reverses forward step i+1, so rcon follows idx+1 in EMIT
  assign rc_step = (state == FWD) ? step : rkey_idx + 4'd1;
  assign rcon    = 8'h01 << (rc_step[3:1] - 3'd1);
  assign t_even  = sub_b ^ {rcon, 24'h0};
  assign t_odd   = sub_a;
  assign fwd_a   = chain(half_a, t_even);
  assign fwd_b   = chain(half_b, t_odd);
  assign undo_a  = unchain(half_a, t_even);
  assign undo_b  = unchain(half_b, t_odd);

  assign busy       = (state != IDLE);
  assign rkey_valid = (state == EMIT);
  assign rkey       = (state == EMIT) ? (rkey_idx[0] ? half_b : half_a) : '0;

`ifdef AES_INVKEY_CACHE_EN
  logic [255:0] cache;
  logic         cache_valid;

  assign use_cache = reuse && cache_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache       <= '0;
      cache_valid <= 1'b0;
    end else if (state == FWD && step == 4'd14) begin
      cache       <= {fwd_a, half_b};
      cache_valid <= 1'b1;
    end
  end
`else
  assign use_cache = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = use_cache ? EMIT : FWD;
      FWD:     if (step == 4'd14) state_next = EMIT;
      EMIT:    if (rkey_ready && rkey_idx == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_a   <= '0;
      half_b   <= '0;
      step     <= '0;
      rkey_idx <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef AES_INVKEY_CACHE_EN
            if (use_cache) begin
              {half_a, half_b} <= cache;
              rkey_idx         <= 4'd14;
            end else begin
              half_a <= key[255:128];
              half_b <= key[127:0];
              step   <= 4'd2;
            end
`else
            half_a <= key[255:128];
            half_b <= key[127:0];
            step   <= 4'd2;
`endif
          end
        end
        FWD: begin
          if (step[0]) half_b <= fwd_b;
          else         half_a <= fwd_a;
          step <= step + 4'd1;
          if (step == 4'd14) rkey_idx <= 4'd14;
        end
        EMIT: begin
          if (rkey_ready) begin
            if (rkey_idx != 4'd14 && rkey_idx != 4'd0) begin
              if (rkey_idx[0]) half_a <= undo_a;
              else             half_b <= undo_b;
            end
            if (rkey_idx != 4'd0) rkey_idx <= rkey_idx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Directed bench for aes256_inv_key_sched using the FIPS-197 AES-256 example key schedule.
// Cache scenarios are compiled in only with AES_INVKEY_CACHE_EN.
module tb_aes256_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key;
  logic         start;
  logic         busy;
  logic [127:0] rkey;
  logic [3:0]   rkey_idx;
  logic         rkey_valid;
  logic         rkey_ready;
`ifdef AES_INVKEY_CACHE_EN
  logic         reuse;
`endif

  int passed = 0;
  int total  = 0;
  logic [127:0] exp_rk [0:14];

  localparam logic [255:0] KEY0    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ALT = {8{32'hdeadbeef}};

  always #5 clk = ~clk;

  aes256_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .start     (start),
`ifdef AES_INVKEY_CACHE_EN
    .reuse     (reuse),
`endif
    .busy      (busy),
    .rkey      (rkey),
    .rkey_idx  (rkey_idx),
    .rkey_valid(rkey_valid),
    .rkey_ready(rkey_ready)
  );

  // Counts edges from the start-sampling edge (edge 1) until rkey_valid is seen.
  task automatic wait_valid(input bit poke, output int edges);
    edges = 0;
    while (rkey_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      start = poke && (edges == 3 || edges == 7);
      if (poke) key = KEY_ALT;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    rkey_ready = 1'b0;
    key = '0;
`ifdef AES_INVKEY_CACHE_EN
    reuse = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, rkey_valid, rkey_idx, rkey} !== 134'h0)
      $display("FAIL reset_state got busy=%b valid=%b idx=%0d rkey=%h expected all zero",
               busy, rkey_valid, rkey_idx, rkey);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence(input bit stall, input bit poke, input string tag);
    int edges;
    int idx_exp;
    int guard;
    bit held_ok;
    logic [132:0] held;
    @(negedge clk);
    key = KEY0;
    start = 1'b1;
    rkey_ready = 1'b1;
`ifdef AES_INVKEY_CACHE_EN
    reuse = 1'b0;
`endif
    wait_valid(poke, edges);
    total++;
    if (edges !== 14) $display("FAIL %s_latency got %0d edges expected 14", tag, edges);
    else passed++;
    idx_exp = 14;
    guard = 0;
    held_ok = 1'b0;
    held = '0;
    while (idx_exp >= 0 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (held_ok) begin
        total++;
        if ({rkey_valid, rkey_idx, rkey} !== held)
          $display("FAIL %s_stall_hold got %h expected %h", tag, {rkey_valid, rkey_idx, rkey}, held);
        else passed++;
      end
      if (poke) begin
        start = (idx_exp == 10 || idx_exp == 5);
        key = KEY_ALT;
      end
      rkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rkey_ready) begin
        total++;
        if ({rkey_valid, rkey_idx, rkey} !== {1'b1, 4'(idx_exp), exp_rk[idx_exp]})
          $display("FAIL %s_key[%0d] got valid=%b idx=%0d rkey=%h expected valid=1 idx=%0d rkey=%h",
                   tag, idx_exp, rkey_valid, rkey_idx, rkey, idx_exp, exp_rk[idx_exp]);
        else passed++;
        idx_exp--;
        held_ok = 1'b0;
      end else begin
        held = {rkey_valid, rkey_idx, rkey};
        held_ok = 1'b1;
      end
    end
    start = 1'b0;
    total++;
    if (idx_exp >= 0) $display("FAIL %s_drain_timeout got idx %0d remaining expected -1", tag, idx_exp);
    else passed++;
    @(negedge clk);
    total++;
    if ({busy, rkey_valid} !== 2'b00)
      $display("FAIL %s_idle_after got busy=%b valid=%b expected 0 0", tag, busy, rkey_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int edges;
    int guard;
    @(negedge clk);
    key = KEY0;
    start = 1'b1;
    rkey_ready = 1'b1;
    wait_valid(1'b0, edges);
    guard = 0;
    @(negedge clk);
    while (rkey_idx !== 4'd7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (rkey_idx !== 4'd7 || rkey_valid !== 1'b1)
      $display("FAIL mid_reach_idx7 got idx=%0d valid=%b expected 7 1", rkey_idx, rkey_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, rkey_valid, rkey_idx, rkey} !== 134'h0)
      $display("FAIL mid_reset_async got busy=%b valid=%b idx=%0d rkey=%h expected all zero",
               busy, rkey_valid, rkey_idx, rkey);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if ({busy, rkey_valid, rkey_idx, rkey} !== 134'h0)
        $display("FAIL mid_reset_discard got busy=%b valid=%b idx=%0d expected all zero",
                 busy, rkey_valid, rkey_idx);
      else passed++;
    end
    test_sequence(1'b0, 1'b0, "after_reset");
  endtask

`ifdef AES_INVKEY_CACHE_EN
  task automatic test_cache_reuse;
    int edges;
    int guard;
    int idx_exp;
    @(negedge clk);
    key = KEY_ALT;
    start = 1'b1;
    reuse = 1'b1;
    rkey_ready = 1'b0;
    wait_valid(1'b0, edges);
    reuse = 1'b0;
    total++;
    if (edges !== 1) $display("FAIL cache_latency got %0d edges expected 1", edges);
    else passed++;
    idx_exp = 14;
    guard = 0;
    while (idx_exp >= 0 && guard < 40) begin
      @(negedge clk);
      guard++;
      rkey_ready = 1'b1;
      total++;
      if ({rkey_idx, rkey} !== {4'(idx_exp), exp_rk[idx_exp]})
        $display("FAIL cache_key[%0d] got idx=%0d rkey=%h expected %h",
                 idx_exp, rkey_idx, rkey, exp_rk[idx_exp]);
      else passed++;
      idx_exp--;
    end
    @(negedge clk);
  endtask

  task automatic test_cache_after_reset;
    int edges;
    int guard;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    key = KEY0;
    start = 1'b1;
    reuse = 1'b1;
    rkey_ready = 1'b1;
    wait_valid(1'b0, edges);
    reuse = 1'b0;
    total++;
    if (edges !== 14) $display("FAIL cache_reset_latency got %0d edges expected 14", edges);
    else passed++;
    total++;
    if (rkey !== exp_rk[14]) $display("FAIL cache_reset_key14 got %h expected %h", rkey, exp_rk[14]);
    else passed++;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
  endtask
`endif

  initial begin
    exp_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    exp_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    exp_rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    exp_rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    exp_rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    exp_rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    exp_rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    exp_rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    exp_rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    exp_rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    exp_rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    exp_rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    exp_rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    exp_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    exp_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    test_reset();
    test_sequence(1'b0, 1'b0, "full");
    test_sequence(1'b1, 1'b0, "stall");
    test_sequence(1'b0, 1'b1, "start_ignored");
    test_reset_mid();
`ifdef AES_INVKEY_CACHE_EN
    test_cache_reuse();
    test_cache_after_reset();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
